// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronizes, debounces and edge-detects N push-buttons, with optional auto-repeat press pulses
// Ports: clk/reset (sync, active-high); btn_raw[N_BTN] async pins in;
//        btn_level debounced level, btn_press press/repeat pulse, btn_release release pulse (all registered).
module button_pulse_gen #(
    parameter int               N_BTN           = 3,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = '0,
    parameter int               REPEAT_DELAY    = 50000000,
    parameter int               REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    // bit 1 of the encoding is the debounced level, so btn_level comes straight off a flop
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        ARM_PRESS   = 2'b01,
        HELD        = 2'b10,
        ARM_RELEASE = 2'b11
    } state_t;
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          s1_q, s2_q;
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic [RW-1:0] rpt_q, rpt_d;
        logic          press_q, press_d, release_q, release_d;
        logic          mismatch, done, rpt_fire;
        always_comb begin
            mismatch  = s2_q ^ state_q[1];
            cnt_inc   = cnt_q + CW'(1);
            done      = mismatch && cnt_inc == CW'(DEBOUNCE_CYCLES);
            cnt_d     = (mismatch && !done) ? cnt_inc : '0;
            case (state_q)
                IDLE, ARM_PRESS: state_d = !s2_q ? IDLE : done ? HELD : ARM_PRESS;
                default:         state_d = s2_q ? HELD : done ? IDLE : ARM_RELEASE;
            endcase
            // rpt_q counts down cycles to the next repeat; a pending release suppresses it
            rpt_fire  = REPEAT_MASK[i] && state_q[1] && !done && rpt_q == RW'(1);
            press_d   = (done && !state_q[1]) || rpt_fire;
            release_d = done && state_q[1];
            rpt_d     = (!REPEAT_MASK[i] || !state_d[1]) ? '0 :
                        done     ? RW'(REPEAT_DELAY)  :
                        rpt_fire ? RW'(REPEAT_PERIOD) : rpt_q - RW'(1);
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                state_q   <= IDLE;
                cnt_q     <= '0;
                rpt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                s1_q      <= btn_raw[i];
                s2_q      <= s1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                rpt_q     <= rpt_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end
        assign btn_level[i]   = state_q[1];
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: scoreboard bench for button_pulse_gen against a sample-window reference model
module tb_button_pulse_gen;
    localparam int         N    = 3;
    localparam int         D    = 4;
    localparam int         RD   = 10;
    localparam int         RP   = 3;
    localparam logic [2:0] MASK = 3'b011;
    localparam int         HN   = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn_raw = 3'b000;
    logic [2:0] btn_level, btn_press, btn_release;

    button_pulse_gen #(
        .N_BTN(N), .DEBOUNCE_CYCLES(D), .REPEAT_MASK(MASK),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] p;
        logic [2:0] r;
    } ev_t;

    ev_t        q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = -1;
    logic [2:0] hist [0:HN-1] = '{default: 3'b000};
    logic [2:0] exp_level = 3'b000;
    int         pe [N];
    bit         started = 1'b0;
    int         fp [N], fr [N], cp [N], cr [N];

    // Reference model: a level flips once the last D synchronized samples all disagree
    // with it; synchronized sample at edge k is the raw value taken at edge k-2.
    always @(posedge clk) begin
        logic [2:0] ep, er;
        bit         stable;
        int         dt;
        cyc++;
        ep = '0;
        er = '0;
        if (reset) begin
            hist[cyc] = '0;
            if (cyc > 0) hist[cyc-1] = '0;
            exp_level = '0;
        end else begin
            hist[cyc] = btn_raw;
            for (int c = 0; c < N; c++) begin
                stable = (cyc >= D + 1);
                if (stable)
                    for (int j = 0; j < D; j++)
                        if (hist[cyc-2-j][c] == exp_level[c]) stable = 1'b0;
                if (stable) begin
                    if (exp_level[c]) er[c] = 1'b1;
                    else begin
                        ep[c] = 1'b1;
                        pe[c] = cyc;
                    end
                    exp_level[c] = ~exp_level[c];
                end else if (exp_level[c] && MASK[c]) begin
                    dt = cyc - pe[c];
                    if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) ep[c] = 1'b1;
                end
            end
            if ((ep | er) != 3'b000) q.push_back('{cyc, ep, er});
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (started) begin
            checks++;
            if (btn_level !== exp_level) begin
                errors++;
                $display("FAIL level cyc=%0d got=%b exp=%b", cyc, btn_level, exp_level);
            end
            if ((btn_press | btn_release) !== 3'b000) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b exp=none", cyc, btn_press, btn_release);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.p !== btn_press || e.r !== btn_release) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d press=%b release=%b exp_cyc=%0d exp_press=%b exp_release=%b",
                                 cyc, btn_press, btn_release, e.cyc, e.p, e.r);
                    end
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d got=none exp_cyc=%0d exp_press=%b exp_release=%b",
                         cyc, q[0].cyc, q[0].p, q[0].r);
                void'(q.pop_front());
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < N; c++) begin
            fp[c] = -1;
            fr[c] = -1;
            cp[c] = 0;
            cr[c] = 0;
        end
    endtask

    task automatic hold(input logic [2:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (btn_press[c]) begin
                    if (fp[c] < 0) fp[c] = cyc;
                    cp[c]++;
                end
                if (btn_release[c]) begin
                    if (fr[c] < 0) fr[c] = cyc;
                    cr[c]++;
                end
            end
        end
    endtask

    initial begin
        int t, t2;
        repeat (3) @(negedge clk);
        started = 1'b1;
        chk("reset_state", int'({btn_level, btn_press, btn_release}), 0);
        reset = 1'b0;
        // clean press/release on channel 2 (no repeat)
        clr();
        t = cyc + 1;
        hold(3'b100, 40);
        t2 = cyc + 1;
        hold(3'b000, 20);
        chk("press_latency", fp[2] - t, 5);
        chk("press_count_ch2", cp[2], 1);
        chk("release_latency", fr[2] - t2, 5);
        chk("release_count_ch2", cr[2], 1);
        // bounce then stable high
        clr();
        repeat (5) begin
            hold(3'b100, 2);
            hold(3'b000, 2);
        end
        t = cyc + 1;
        hold(3'b100, 20);
        hold(3'b000, 20);
        chk("bounce_press_latency", fp[2] - t, 5);
        chk("bounce_press_count", cp[2], 1);
        // auto-repeat on channel 0
        clr();
        t = cyc + 1;
        hold(3'b001, 30);
        hold(3'b000, 20);
        chk("repeat_first_press", fp[0] - t, 5);
        chk("repeat_press_count", cp[0], 8);
        chk("repeat_release_at", fr[0] - t, 35);
        chk("repeat_release_count", cr[0], 1);
        // simultaneous press on channels 0 and 1
        clr();
        t = cyc + 1;
        hold(3'b011, 30);
        hold(3'b000, 20);
        chk("simul_first_ch0", fp[0] - t, 5);
        chk("simul_first_ch1", fp[1] - t, 5);
        chk("simul_count_ch0", cp[0], 8);
        chk("simul_count_ch1", cp[1], 8);
        chk("simul_quiet_ch2", cp[2] + cr[2], 0);
        // reset while channel 1 is held
        hold(3'b010, 20);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_hold", int'({btn_level, btn_press, btn_release}), 0);
        reset = 1'b0;
        clr();
        t = cyc + 1;
        hold(3'b010, 20);
        hold(3'b000, 20);
        chk("post_reset_press", fp[1] - t, 5);
        // short release glitch while held on channel 0
        clr();
        t = cyc + 1;
        hold(3'b001, 20);
        hold(3'b000, 3);
        hold(3'b001, 20);
        hold(3'b000, 20);
        chk("glitch_press_count", cp[0], 12);
        chk("glitch_release_count", cr[0], 1);
        chk("glitch_release_at", fr[0] - t, 48);
        // random segments with occasional reset
        repeat (150) begin
            if ($urandom_range(0, 30) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            hold(3'($urandom_range(0, 7)), $urandom_range(1, 12));
        end
        hold(3'b000, 30);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Input conditioner for the pong board's push-buttons. It synchronizes and debounces N raw button inputs. It produces a clean level, a one-cycle press pulse and a one-cycle release pulse per button. Selected buttons can be given auto-repeat press pulses while held. It sits between the board pins and the consumers of the buttons: the start menu's up/down/enter inputs and the paddle controls. Every consumer receives exactly one pulse per physical press, not one per clock while held.

## Interface
- N_BTN, 3: number of button channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable samples required to accept a level change (10 ms at 100 MHz); must be ≥1.
- REPEAT_MASK, 0: per-channel auto-repeat enable, N_BTN bits.
- REPEAT_DELAY, 50000000: cycles from the initial press pulse to the first repeat pulse; must be ≥2.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses; must be ≥2.

- clk  in  1  100 MHz system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- btn_raw  in  N_BTN  asynchronous raw button pins, active-high.
- btn_level  out  N_BTN  debounced button level, registered.
- btn_press  out  N_BTN  one-cycle pulse on accepted press and on each auto-repeat, registered.
- btn_release  out  N_BTN  one-cycle pulse on accepted release, registered.

## Operation
- Every channel is independent and identical. Channels share no state.
- Synchronizer: two flops per channel (s1, s2), both reset to 0. Only s2 is used downstream.
- Debounce:
  - A per-channel counter, width $clog2(DEBOUNCE_CYCLES+1), counts the consecutive sampled cycles where s2 ≠ btn_level.
  - If s2 equals btn_level on any cycle, the counter clears to 0.
  - When the counter would reach DEBOUNCE_CYCLES, btn_level toggles and the counter clears.
- Per-channel state machine:
  - IDLE (level 0): s2=1 → ARM_PRESS.
  - ARM_PRESS: s2=0 → IDLE with no output. Count complete → HELD, btn_level←1, btn_press←1 for one cycle.
  - HELD (level 1): s2=0 → ARM_RELEASE.
  - ARM_RELEASE: s2=1 → HELD with no output. Count complete → IDLE, btn_level←0, btn_release←1 for one cycle.
- Auto-repeat:
  - Applies only to channels with REPEAT_MASK bit set.
  - In HELD and ARM_RELEASE, a repeat counter (width sized to max(REPEAT_DELAY, REPEAT_PERIOD)) runs.
  - First repeat pulse comes REPEAT_DELAY cycles after the initial press pulse. Each later pulse comes REPEAT_PERIOD cycles after the previous one.
  - The repeat counter clears on entry to IDLE.
  - No repeat pulse is issued on the cycle that the release is accepted.
- Masked-off channels never emit more than one btn_press per accepted press.
- btn_press and btn_release are never high together on one channel.
- btn_press is never high on two consecutive cycles on one channel.

## Timing
- Reset: s1, s2, counters, btn_level, btn_press and btn_release all become 0, and every channel goes to IDLE on the edge where reset is sampled high. This holds mid-debounce, mid-hold and mid-repeat.
- A button held through reset is seen as a fresh press after reset deasserts. It is not seen as already-held.
- Press latency: btn_raw goes high before edge 0 and stays high. s2=1 is first sampled at edge 2. btn_level and btn_press are updated at edge DEBOUNCE_CYCLES+1, so the total latency is DEBOUNCE_CYCLES+2 rising edges, counting edge 0. Release latency is identical.
- A glitch shorter than DEBOUNCE_CYCLES sampled cycles produces no output change. The counter restarts from 0 on the next deviation.
- Repeat timing: the initial press pulse is at edge P. Repeat pulses fall at edges P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD.
- There is no combinational path from btn_raw to any output.

## Test plan
All scenarios use N_BTN=3, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_MASK=3'b011.
- Clean press on btn_raw[2] before edge 0, held for 40 cycles, then released:
  - btn_level[2] rises and btn_press[2] pulses for exactly one cycle at edge 5.
  - No further press pulses on channel 2.
  - btn_release[2] pulses 6 edges after the raw fall.
- Bounce on btn_raw[2]: toggle high/low every 2 cycles for 20 cycles, then hold high:
  - No output during the bounce.
  - A single btn_press[2] at edge 5, counted from the first high sample after bouncing stops.
- Auto-repeat on channel 0, held for 30 cycles:
  - btn_press[0] pulses at edges P, P+10, P+13, P+16, and so on every 3 cycles until the release is accepted.
  - btn_release[0] then pulses once.
- Simultaneous press on btn_raw[0] and btn_raw[1] on the same cycle:
  - Both channels pulse btn_press at the same edge, edge 5.
  - Their repeat pulses stay aligned.
  - Channel 2 stays quiet.
- Reset mid-hold: assert reset for 1 cycle while channel 1 is in HELD with btn_raw[1] still high:
  - All outputs are 0 the cycle after reset.
  - A fresh btn_press[1] appears 6 edges after reset deasserts.
- Release glitch: while HELD, drop btn_raw[0] low for 3 cycles:
  - btn_level[0] stays 1 and no btn_release is emitted.
  - The repeat cadence continues unchanged.
